counter_scan_ctrl: RTL and testbench
====================================

# counter_scan_ctrl

Sequencing controller for the 4-bit loadable up/down counter (active-low LOAD, EN, UPDN, D, QN, CO). On a START request it loads a low bound into the counter, then ping-pongs it LO→HI→LO for a programmed number of passes. It reports BUSY, a one-cycle DONE pulse and an ERR flag. It sits between a host/FSM issuing scan requests and the counter instance, and is the only driver of the counter's LOAD/EN/UPDN/D.

## Interface
- No parameters. Widths are fixed to the 4-bit counter.
- CLK  in  1  rising-edge clock, shared with the counter
- MR  in  1  reset, synchronous, active-high
- START  in  1  scan request, sampled only in IDLE
- ABORT  in  1  cancel the scan in progress
- LO  in  4  low bound, latched at START
- HI  in  4  high bound, latched at START
- PASSES  in  4  pass count, latched at START; 0 means 16
- QN  in  4  counter value
- CO  in  1  counter wrap flag
- LOAD  out  1  counter load, active-low
- EN  out  1  counter enable
- UPDN  out  1  0 = up, 1 = down
- D  out  4  counter load data; always equals latched LO
- BUSY  out  1  scan in progress
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  error flag, sticky until the next accepted START
- PASS_CNT  out  4  index of the current pass, starting at 0

## Operation
- States are IDLE, LOAD, UP, DOWN, FIN.
- Registers: state, LO_r, HI_r, a 5-bit pass target, a 5-bit pass counter, and ERR.
- Reset values: state=IDLE, LO_r=HI_r=0, LOAD=1, EN=0, UPDN=0, D=0, BUSY=0, DONE=0, ERR=0, PASS_CNT=0.
- Outputs are a Mealy decode of state, QN and the latched bounds. The counter must step on the same edge that the decision is made.
- IDLE:
  - LOAD=1, EN=0.
  - If START=1, latch LO/HI/PASSES, clear ERR and the pass counter.
  - Go to FIN with ERR=1 if LO>HI; otherwise go to LOAD.
- LOAD: drive LOAD=0, EN=0, BUSY=1. Next state is UP.
- UP:
  - Drive UPDN=0, EN=(QN!=HI_r), BUSY=1.
  - When QN==HI_r, go to DOWN.
- DOWN:
  - Drive UPDN=1, EN=(QN!=LO_r), BUSY=1.
  - When QN==LO_r, the pass is complete: if pass counter+1 == target, go to FIN; else increment the pass counter and go to UP.
- FIN: drive DONE=1, BUSY=0, EN=0, LOAD=1. Next state is IDLE.
- CO==1 in UP or DOWN means the counter overshot. Set ERR=1 and go to FIN. EN is forced to 0 in that cycle.
- ABORT==1 in LOAD, UP or DOWN:
  - Next state is IDLE, with no DONE pulse and ERR unchanged.
  - EN=0 and LOAD=1 in that cycle.
  - ABORT takes priority over CO and QN compares; ABORT in IDLE or FIN is ignored.
- START is ignored outside IDLE.
- LO==HI is legal. UP and DOWN then each last one cycle with EN=0, so the counter holds.

## Timing
- START sampled high at edge 0 gives LOAD state in cycle 1 and QN=LO in cycle 2.
- One pass takes 2*(HI-LO)+2 cycles.
- DONE is high in cycle 1 + P*(2*(HI-LO)+2) + 1, where P is the effective pass count (1..16).
- BUSY is high from cycle 1 through the cycle before DONE.
- An LO>HI reject produces DONE=1 and ERR=1 in cycle 1; the counter is never loaded.
- MR=1 at any edge returns all registers to their reset values at that edge, including mid-scan.
- After reset, the counter value is not touched until the next LOAD state.
- A START asserted in the FIN cycle is ignored. A new scan may be accepted in the cycle after DONE.

## Test plan
- LO=2, HI=5, PASSES=1:
  - LOAD=0 in cycle 1.
  - QN sequence is 2,3,4,5,5,4,3,2 over cycles 2–9.
  - DONE=1 in cycle 10 only, ERR=0, BUSY high for cycles 1–9.
- LO=0, HI=15, PASSES=0 (16 passes): DONE in cycle 1+16*32+1=514, CO never asserts, PASS_CNT reaches 15.
- LO=7, HI=7, PASSES=3: EN stays 0 after the load, QN holds 7, DONE in cycle 8.
- LO=9, HI=3, START: DONE=1 and ERR=1 in cycle 1, LOAD never goes to 0.
- LO=1, HI=6, PASSES=2, ABORT in cycle 5: EN=0 in cycle 5, IDLE in cycle 6, no DONE. A new START is then accepted.
- Mid-scan disturbances:
  - Force CO=1 in cycle 4: ERR=1 and DONE in cycle 5.
  - Separately, MR=1 in cycle 6: all outputs at reset values in cycle 7.

Source files
------------

// File: rtl/counter_scan_ctrl.sv
// counter_scan_ctrl
// Sequencing controller for a 4-bit loadable up/down counter. A START in IDLE
// latches LO/HI/PASSES, loads LO into the counter, then ping-pongs the counter
// LO->HI->LO for the programmed number of passes (0 means 16).
//
// Ports:
//   i_clk       rising-edge clock, shared with the counter
//   i_mr        synchronous active-high reset
//   i_start     scan request, sampled only in IDLE
//   i_abort     cancel the scan in progress (LOAD/UP/DOWN only)
//   i_lo/i_hi   scan bounds, latched at START
//   i_passes    pass count, latched at START (0 = 16)
//   i_qn/i_co   counter value and wrap flag
//   o_load      counter load, active-low
//   o_en        counter enable
//   o_updn      counter direction, 0 = up, 1 = down
//   o_d         counter load data (latched LO)
//   o_busy      scan in progress
//   o_done      one-cycle completion pulse
//   o_err       sticky error (LO>HI reject or counter overshoot)
//   o_pass_cnt  index of the current pass
module counter_scan_ctrl (
    input  logic       i_clk,
    input  logic       i_mr,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [3:0] i_lo,
    input  logic [3:0] i_hi,
    input  logic [3:0] i_passes,
    input  logic [3:0] i_qn,
    input  logic       i_co,
    output logic       o_load,
    output logic       o_en,
    output logic       o_updn,
    output logic [3:0] o_d,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [3:0] o_pass_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_UP   = 3'd2;
    localparam logic [2:0] S_DOWN = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [2:0] r_state;
    logic [3:0] r_lo;
    logic [3:0] r_hi;
    logic [4:0] r_target;
    logic [4:0] r_pass;
    logic       r_err;

    logic [2:0] w_next;
    logic       w_accept;
    logic       w_set_err;
    logic       w_pass_inc;
    logic       w_load;
    logic       w_en;
    logic       w_updn;
    logic       w_busy;
    logic       w_done;

    // Mealy decode: EN is computed from the live QN so the counter steps on
    // the same edge that the compare decides the next state.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_set_err  = 1'b0;
        w_pass_inc = 1'b0;
        w_load     = 1'b1;
        w_en       = 1'b0;
        w_updn     = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    w_next   = (i_lo > i_hi) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                w_busy = 1'b1;
                if (i_abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_load = 1'b0;
                    w_next = S_UP;
                end
            end
            S_UP: begin
                w_busy = 1'b1;
                w_updn = 1'b0;
                if (i_abort) begin
                    w_next = S_IDLE;
                end else if (i_co) begin
                    w_set_err = 1'b1;
                    w_next    = S_FIN;
                end else begin
                    w_en = (i_qn != r_hi);
                    if (i_qn == r_hi) w_next = S_DOWN;
                end
            end
            S_DOWN: begin
                w_busy = 1'b1;
                w_updn = 1'b1;
                if (i_abort) begin
                    w_next = S_IDLE;
                end else if (i_co) begin
                    w_set_err = 1'b1;
                    w_next    = S_FIN;
                end else begin
                    w_en = (i_qn != r_lo);
                    if (i_qn == r_lo) begin
                        if (r_pass + 5'd1 == r_target) begin
                            w_next = S_FIN;
                        end else begin
                            w_pass_inc = 1'b1;
                            w_next     = S_UP;
                        end
                    end
                end
            end
            S_FIN: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_mr) begin
            r_state  <= S_IDLE;
            r_lo     <= 4'd0;
            r_hi     <= 4'd0;
            r_target <= 5'd0;
            r_pass   <= 5'd0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_lo     <= i_lo;
                r_hi     <= i_hi;
                // A programmed count of 0 stands for the full 16 passes.
                r_target <= (i_passes == 4'd0) ? 5'd16 : {1'b0, i_passes};
                r_pass   <= 5'd0;
                r_err    <= (i_lo > i_hi);
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (w_pass_inc) r_pass <= r_pass + 5'd1;
        end
    end

    assign o_load     = w_load;
    assign o_en       = w_en;
    assign o_updn     = w_updn;
    assign o_d        = r_lo;
    assign o_busy     = w_busy;
    assign o_done     = w_done;
    assign o_err      = r_err;
    assign o_pass_cnt = r_pass[3:0];

endmodule

// File: tb/tb_counter_scan_ctrl.sv
module tb_counter_scan_ctrl;

    logic       clk = 1'b0;
    logic       mr = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] lo = 4'd0;
    logic [3:0] hi = 4'd0;
    logic [3:0] passes = 4'd0;
    logic [3:0] qn;
    logic       co;
    logic       load, en, updn, busy, done, err;
    logic [3:0] d, pcnt;

    counter_scan_ctrl dut (
        .i_clk(clk), .i_mr(mr), .i_start(start), .i_abort(abort),
        .i_lo(lo), .i_hi(hi), .i_passes(passes), .i_qn(qn), .i_co(co),
        .o_load(load), .o_en(en), .o_updn(updn), .o_d(d), .o_busy(busy),
        .o_done(done), .o_err(err), .o_pass_cnt(pcnt)
    );

    always #5 clk = ~clk;

    // Behavioural 4-bit counter: synchronous active-low load, CO flags a wrap.
    logic [3:0] cq = 4'd0;
    logic       co_r = 1'b0;
    logic       co_force = 1'b0;
    always @(posedge clk) begin
        if (!load) begin
            cq   <= d;
            co_r <= 1'b0;
        end else if (en) begin
            cq   <= updn ? cq - 4'd1 : cq + 4'd1;
            co_r <= updn ? (cq == 4'd0) : (cq == 4'd15);
        end else begin
            co_r <= 1'b0;
        end
    end
    assign qn = cq;
    assign co = co_r | co_force;

    // Edge counter: during scan cycle k (after scan edge 0 at index base) ecount == base+k.
    int ecount = 0;
    int base = 0;
    always @(posedge clk) ecount <= ecount + 1;

    typedef struct { int t; int s; int v; } chk_t;
    typedef struct { int t; int e; } done_t;
    chk_t  eq[$];
    done_t dq[$];
    int vectors = 0;
    int miscompares = 0;

    localparam int S_LOAD = 0, S_EN = 1, S_BUSY = 2, S_DONE = 3, S_ERR = 4,
                   S_QN = 5, S_PCNT = 6, S_UPDN = 7, S_D = 8;

    function automatic int sigval(int s);
        case (s)
            S_LOAD: return int'(load);
            S_EN:   return int'(en);
            S_BUSY: return int'(busy);
            S_DONE: return int'(done);
            S_ERR:  return int'(err);
            S_QN:   return int'(qn);
            S_PCNT: return int'(pcnt);
            S_UPDN: return int'(updn);
            default: return int'(d);
        endcase
    endfunction

    function automatic string signame(int s);
        case (s)
            S_LOAD: return "LOAD";
            S_EN:   return "EN";
            S_BUSY: return "BUSY";
            S_DONE: return "DONE";
            S_ERR:  return "ERR";
            S_QN:   return "QN";
            S_PCNT: return "PASS_CNT";
            S_UPDN: return "UPDN";
            default: return "D";
        endcase
    endfunction

    // Expectation at scan cycle k, kept sorted by absolute cycle.
    function automatic void expect_at(int k, int s, int v);
        chk_t c;
        int i = 0;
        c.t = base + k; c.s = s; c.v = v;
        while (i < eq.size() && eq[i].t <= c.t) i++;
        eq.insert(i, c);
    endfunction

    function automatic void expect_done(int k, int e);
        done_t x;
        x.t = base + k; x.e = e;
        dq.push_back(x);
    endfunction

    // Monitor: pops cycle-tagged checks, and pops a DONE record whenever DONE fires.
    always @(negedge clk) begin
        while (eq.size() > 0 && eq[0].t <= ecount) begin
            chk_t c;
            c = eq.pop_front();
            vectors++;
            if (c.t != ecount) begin
                miscompares++;
                $display("FAIL stale_%s cyc=%0d got_at=%0d", signame(c.s), c.t, ecount);
            end else if (sigval(c.s) != c.v) begin
                miscompares++;
                $display("FAIL %s cyc=%0d actual=%0d required=%0d", signame(c.s), c.t,
                         sigval(c.s), c.v);
            end
        end
        if (done) begin
            vectors++;
            if (dq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_DONE cyc=%0d", ecount);
            end else begin
                done_t x;
                x = dq.pop_front();
                if (x.t != ecount || x.e != int'(err)) begin
                    miscompares++;
                    $display("FAIL DONE cyc actual=%0d required=%0d err actual=%0d required=%0d",
                             ecount, x.t, err, x.e);
                end
            end
        end
    end

    // Advance to scan cycle k (#1 after the edge that opens it).
    task automatic go(int k);
        int n;
        n = base + k - ecount;
        if (n > 0) repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(logic [3:0] l, logic [3:0] h, logic [3:0] p);
        lo = l; hi = h; passes = p; start = 1'b1;
        base = ecount;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        base = ecount;
        expect_at(0, S_LOAD, 1); expect_at(0, S_EN, 0); expect_at(0, S_UPDN, 0);
        expect_at(0, S_D, 0); expect_at(0, S_BUSY, 0); expect_at(0, S_DONE, 0);
        expect_at(0, S_ERR, 0); expect_at(0, S_PCNT, 0);
        go(1);
        mr = 1'b0;
        go(2);

        // Single pass 2..5
        launch(4'd2, 4'd5, 4'd1);
        expect_at(1, S_LOAD, 0);
        for (int k = 1; k <= 9; k++) expect_at(k, S_BUSY, 1);
        begin
            int seq [8] = '{2, 3, 4, 5, 5, 4, 3, 2};
            for (int k = 0; k < 8; k++) expect_at(k + 2, S_QN, seq[k]);
        end
        expect_at(9, S_DONE, 0); expect_at(10, S_BUSY, 0); expect_at(11, S_DONE, 0);
        expect_done(10, 0);
        go(12);

        // Full range, 16 passes
        launch(4'd0, 4'd15, 4'd0);
        expect_at(17, S_QN, 15); expect_at(33, S_QN, 0); expect_at(33, S_PCNT, 0);
        expect_at(34, S_QN, 0); expect_at(34, S_PCNT, 1);
        expect_at(513, S_PCNT, 15); expect_at(513, S_BUSY, 1);
        expect_done(514, 0);
        go(516);

        // Degenerate LO==HI, 3 passes
        launch(4'd7, 4'd7, 4'd3);
        for (int k = 2; k <= 7; k++) begin
            expect_at(k, S_EN, 0);
            expect_at(k, S_QN, 7);
        end
        expect_at(6, S_PCNT, 2);
        expect_done(8, 0);
        go(10);

        // LO>HI reject
        launch(4'd9, 4'd3, 4'd1);
        expect_at(1, S_LOAD, 1); expect_at(1, S_BUSY, 0); expect_at(2, S_LOAD, 1);
        expect_at(2, S_ERR, 1);
        expect_done(1, 1);
        go(3);

        // Abort in cycle 5, then an immediate new scan
        launch(4'd1, 4'd6, 4'd2);
        expect_at(4, S_EN, 1); expect_at(5, S_EN, 0); expect_at(5, S_LOAD, 1);
        expect_at(6, S_BUSY, 0); expect_at(6, S_DONE, 0); expect_at(6, S_ERR, 0);
        go(5);
        abort = 1'b1;
        go(6);
        abort = 1'b0;
        launch(4'd3, 4'd4, 4'd1);
        expect_at(1, S_LOAD, 0); expect_at(3, S_QN, 4);
        expect_done(6, 0);
        go(8);

        // Forced overshoot in cycle 4
        launch(4'd2, 4'd5, 4'd1);
        expect_at(3, S_EN, 1); expect_at(4, S_EN, 0);
        expect_at(5, S_BUSY, 0); expect_at(6, S_ERR, 1); expect_at(6, S_BUSY, 0);
        expect_done(5, 1);
        go(4);
        co_force = 1'b1;
        go(5);
        co_force = 1'b0;
        go(8);

        // Reset mid-scan in cycle 6
        launch(4'd2, 4'd5, 4'd1);
        expect_at(6, S_UPDN, 1); expect_at(6, S_D, 2); expect_at(6, S_BUSY, 1);
        expect_at(7, S_LOAD, 1); expect_at(7, S_EN, 0); expect_at(7, S_UPDN, 0);
        expect_at(7, S_D, 0); expect_at(7, S_BUSY, 0); expect_at(7, S_DONE, 0);
        expect_at(7, S_ERR, 0); expect_at(7, S_PCNT, 0);
        expect_at(7, S_QN, 4); expect_at(9, S_QN, 4); expect_at(9, S_BUSY, 0);
        go(6);
        mr = 1'b1;
        go(7);
        mr = 1'b0;
        go(12);

        if (eq.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_checks actual=%0d required=0", eq.size());
        end
        if (dq.size() != 0) begin
            miscompares++;
            $display("FAIL missing_DONE actual=%0d required=0", dq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
